pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Pipeline control unit for the 5-stage core. Sits beside id/ex and drives the stall and flush
//   controls of pc_reg, if_id and id_ex. It sequences load-use stalls over the RAM read latency,
//   redirects fetch on EX jumps/branches and freezes the whole front end on an external hold
//   request. It also keeps saturating stall and flush counters for performance monitoring.
// PARAMETERS
//   LOAD_LAT   1    bubbles inserted per load-use hazard (>=1)
//   CNT_W      32   width of the stall/flush performance counters
// PORTS
//   clk               in   1      core clock, rising edge
//   arst_n            in   1      asynchronous reset, active-low
//   id_reg1_r_addr_i  in   5      rs1 of the instruction in ID
//   id_reg2_r_addr_i  in   5      rs2 of the instruction in ID
//   id_reg1_use_i     in   1      ID instruction actually reads rs1
//   id_reg2_use_i     in   1      ID instruction actually reads rs2
//   ex_reg_w_addr_i   in   5      rd of the instruction in EX
//   ex_reg_w_ena_i    in   1      EX instruction writes rd
//   ex_mem_r_ena_i    in   1      EX instruction is a load
//   ex_jump_ena_i     in   1      EX resolved a taken branch/jal/jalr
//   ex_jump_addr_i    in   32     target PC from EX
//   hold_req_i        in   1      external freeze (bus/multicycle unit busy)
//   jump_ena_o        out  1      redirect pc_reg this cycle
//   jump_addr_o       out  32     redirect target
//   pc_stall_o        out  1      pc_reg keeps its value
//   if_id_stall_o     out  1      if_id keeps its contents
//   if_id_flush_o     out  1      if_id loads a NOP
//   id_ex_stall_o     out  1      id_ex keeps its contents
//   id_ex_flush_o     out  1      id_ex loads a bubble (all write/mem enables 0)
//   stall_cnt_o       out  CNT_W  cycles with pc_stall_o=1, saturating
//   flush_cnt_o       out  CNT_W  redirects taken, saturating
// BEHAVIOUR
//   - Reset: state=RUN, bubble counter=0, both perf counters=0. While arst_n=0 all control outputs
//     and jump_addr_o are 0.
//   - hazard = ex_mem_r_ena_i & ex_reg_w_ena_i & (ex_reg_w_addr_i!=0) &
//     ((id_reg1_use_i & rs1==rd) | (id_reg2_use_i & rs2==rd)). Hazard is evaluated only in RUN.
//   - Control outputs are combinational from state and inputs; state and counters are registered.
//   - Priority every cycle is hold > jump > load-use.
//   - FSM states: RUN, LSTALL, HOLD. The HOLD state stores its return state and bubble count.
//   - RUN, hold_req_i=1: pc_stall, if_id_stall and id_ex_stall are 1; no flush; jump_ena_o=0.
//     Next state is HOLD (return=RUN).
//   - RUN, jump: jump_ena_o=1, jump_addr_o=ex_jump_addr_i, if_id_flush=id_ex_flush=1 in the same
//     cycle. Next state is RUN.
//   - RUN, hazard: pc_stall=if_id_stall=id_ex_flush=1.
//     If LOAD_LAT==1, stay in RUN. Otherwise go to LSTALL with cnt=LOAD_LAT-1.
//   - LSTALL: pc_stall=if_id_stall=id_ex_flush=1 and cnt decrements.
//     When cnt==1 at the clock edge, next state is RUN.
//   - LSTALL, hold: freeze. Use id_ex_stall, not flush, and do not decrement cnt.
//     Go to HOLD with return=LSTALL and cnt preserved.
//   - LSTALL, jump (defensive): the jump is taken as in RUN, cnt is cleared, next state is RUN.
//   - HOLD: stall all three while hold_req_i=1. A jump pending in the frozen EX is not emitted.
//     On the first cycle with hold_req_i=0, behave as the return state that same cycle, so a
//     pending jump/hazard takes effect without loss.
//   - stall_cnt increments on every cycle with pc_stall_o=1. flush_cnt increments on every cycle
//     with jump_ena_o=1. Both stick at 2^CNT_W-1.
//   - Reset asserted mid-stall or mid-hold returns to RUN immediately; no pending event survives.
// TESTING
//   - lw x5 in EX, add x6,x5,x1 in ID (rs1=5, rd=5, load) -> exactly 1 cycle of pc_stall,
//     if_id_stall and id_ex_flush; stall_cnt=1.
//   - LOAD_LAT=3, same hazard -> 3 consecutive stall cycles, RUN on the 4th; stall_cnt=3.
//   - ex_jump_ena_i=1, addr=0x0000_0100 -> same-cycle jump_ena_o=1, jump_addr_o=0x100,
//     both flushes=1, flush_cnt=1.
//   - Hazard with rd=x0, or with use bit=0 -> no stall.
//   - LOAD_LAT=3; hold_req_i for 4 cycles during the 2nd bubble -> all stalls held, no flush,
//     cnt frozen; after release 2 more bubbles; stall_cnt=7.
//   - hold_req_i=1 with ex_jump_ena_i=1 for 2 cycles, then hold drops -> jump_ena_o=0 while held,
//     1 on the release cycle; CNT_W=2 perf counters saturate at 3. Assert arst_n=0 mid-LSTALL
//     -> all outputs 0, RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX observation inputs
// plus the stall/flush/redirect controls returned to pc_reg, if_id and id_ex.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_reg1_r_addr_i;
  logic [4:0]  id_reg2_r_addr_i;
  logic        id_reg1_use_i;
  logic        id_reg2_use_i;
  logic [4:0]  ex_reg_w_addr_i;
  logic        ex_reg_w_ena_i;
  logic        ex_mem_r_ena_i;
  logic        ex_jump_ena_i;
  logic [31:0] ex_jump_addr_i;
  logic        hold_req_i;

  logic        jump_ena_o;
  logic [31:0] jump_addr_o;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_stall_o;
  logic        id_ex_flush_o;

  modport master (
    output id_reg1_r_addr_i, id_reg2_r_addr_i, id_reg1_use_i, id_reg2_use_i,
           ex_reg_w_addr_i, ex_reg_w_ena_i, ex_mem_r_ena_i, ex_jump_ena_i,
           ex_jump_addr_i, hold_req_i,
    input  jump_ena_o, jump_addr_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
           id_ex_stall_o, id_ex_flush_o
  );

  modport slave (
    input  id_reg1_r_addr_i, id_reg2_r_addr_i, id_reg1_use_i, id_reg2_use_i,
           ex_reg_w_addr_i, ex_reg_w_ena_i, ex_mem_r_ena_i, ex_jump_ena_i,
           ex_jump_addr_i, hold_req_i,
    output jump_ena_o, jump_addr_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
           id_ex_stall_o, id_ex_flush_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: load-use bubbles, EX redirects and external freeze,
// with priority hold > jump > load-use, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  pipe_hazard_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  localparam int unsigned BW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [BW-1:0] BUBBLES_M1 = BW'(LOAD_LAT - 1);

  typedef enum logic [1:0] {RUN, LSTALL, HOLD} state_e;

  state_e          state_q, state_d;
  state_e          retState_q, retState_d;
  state_e          effState;
  logic [BW-1:0]   bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

  logic hazard;
  logic jumpEna, pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush;

  assign hazard = bus.ex_mem_r_ena_i & bus.ex_reg_w_ena_i & (bus.ex_reg_w_addr_i != 5'd0) &
                  ((bus.id_reg1_use_i & (bus.id_reg1_r_addr_i == bus.ex_reg_w_addr_i)) |
                   (bus.id_reg2_use_i & (bus.id_reg2_r_addr_i == bus.ex_reg_w_addr_i)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RUN;
      retState_q  <= RUN;
      bubbleCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      retState_q  <= retState_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  // Leaving HOLD acts as the saved state in the same cycle so no event is lost.
  always_comb begin
    state_d     = state_q;
    retState_d  = retState_q;
    bubbleCnt_d = bubbleCnt_q;
    jumpEna     = 1'b0;
    pcStall     = 1'b0;
    ifIdStall   = 1'b0;
    ifIdFlush   = 1'b0;
    idExStall   = 1'b0;
    idExFlush   = 1'b0;

    effState = (state_q == HOLD && !bus.hold_req_i) ? retState_q : state_q;

    case (effState)
      HOLD: begin
        pcStall   = 1'b1;
        ifIdStall = 1'b1;
        idExStall = 1'b1;
        state_d   = HOLD;
      end
      RUN: begin
        if (bus.hold_req_i) begin
          pcStall    = 1'b1;
          ifIdStall  = 1'b1;
          idExStall  = 1'b1;
          state_d    = HOLD;
          retState_d = RUN;
        end else if (bus.ex_jump_ena_i) begin
          jumpEna     = 1'b1;
          ifIdFlush   = 1'b1;
          idExFlush   = 1'b1;
          state_d     = RUN;
          bubbleCnt_d = '0;
        end else if (hazard) begin
          pcStall   = 1'b1;
          ifIdStall = 1'b1;
          idExFlush = 1'b1;
          if (LOAD_LAT == 1) begin
            state_d = RUN;
          end else begin
            state_d     = LSTALL;
            bubbleCnt_d = BUBBLES_M1;
          end
        end else begin
          state_d = RUN;
        end
      end
      LSTALL: begin
        if (bus.hold_req_i) begin
          pcStall    = 1'b1;
          ifIdStall  = 1'b1;
          idExStall  = 1'b1;
          state_d    = HOLD;
          retState_d = LSTALL;
        end else if (bus.ex_jump_ena_i) begin
          jumpEna     = 1'b1;
          ifIdFlush   = 1'b1;
          idExFlush   = 1'b1;
          state_d     = RUN;
          bubbleCnt_d = '0;
        end else begin
          pcStall   = 1'b1;
          ifIdStall = 1'b1;
          idExFlush = 1'b1;
          if (bubbleCnt_q <= BW'(1)) begin
            state_d     = RUN;
            bubbleCnt_d = '0;
          end else begin
            state_d     = LSTALL;
            bubbleCnt_d = bubbleCnt_q - BW'(1);
          end
        end
      end
      default: begin
        state_d     = RUN;
        retState_d  = RUN;
        bubbleCnt_d = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even with live hazard inputs.
  assign bus.jump_ena_o    = arst_n & jumpEna;
  assign bus.jump_addr_o   = (arst_n & jumpEna) ? bus.ex_jump_addr_i : 32'd0;
  assign bus.pc_stall_o    = arst_n & pcStall;
  assign bus.if_id_stall_o = arst_n & ifIdStall;
  assign bus.if_id_flush_o = arst_n & ifIdFlush;
  assign bus.id_ex_stall_o = arst_n & idExStall;
  assign bus.id_ex_flush_o = arst_n & idExFlush;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (pcStall && (stallCnt_q != {CNT_W{1'b1}})) begin
        stallCnt_q <= stallCnt_q + CNT_W'(1);
      end
      if (jumpEna && (flushCnt_q != {CNT_W{1'b1}})) begin
        flushCnt_q <= flushCnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three controller instances (LOAD_LAT 1/3, narrow counters)
// share directed stimulus; a negedge monitor checks queued expectations.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        rstn;
    logic        hold;
    logic        jmp;
    logic [31:0] jaddr;
    logic        load;
    logic        wena;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        use1;
    logic [4:0]  rs2;
    logic        use2;
  } stim_t;

  typedef struct {
    int          dut;
    string       name;
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [31:0] sCnt;
    logic [31:0] fCnt;
  } exp_t;

  // ctl bits: jump, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_HAZ  = 6'b011001;
  localparam logic [5:0] C_HOLD = 6'b011010;
  localparam logic [5:0] C_JMP  = 6'b100101;

  logic  clk;
  logic  arst_n;
  stim_t st;
  exp_t  expQ[$];
  int    testsRun;
  int    testsFailed;

  logic [31:0] sCntA, fCntA, sCntB, fCntB;
  logic [1:0]  sCntC, fCntC;

  pipe_hazard_ctrl_if ifs[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_drive
    assign ifs[g].id_reg1_r_addr_i = st.rs1;
    assign ifs[g].id_reg2_r_addr_i = st.rs2;
    assign ifs[g].id_reg1_use_i    = st.use1;
    assign ifs[g].id_reg2_use_i    = st.use2;
    assign ifs[g].ex_reg_w_addr_i  = st.rd;
    assign ifs[g].ex_reg_w_ena_i   = st.wena;
    assign ifs[g].ex_mem_r_ena_i   = st.load;
    assign ifs[g].ex_jump_ena_i    = st.jmp;
    assign ifs[g].ex_jump_addr_i   = st.jaddr;
    assign ifs[g].hold_req_i       = st.hold;
  end

  assign arst_n = st.rstn;

  pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(32)) dutA (
    .clk(clk), .arst_n(arst_n), .bus(ifs[0]), .stall_cnt_o(sCntA), .flush_cnt_o(fCntA));
  pipe_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(32)) dutB (
    .clk(clk), .arst_n(arst_n), .bus(ifs[1]), .stall_cnt_o(sCntB), .flush_cnt_o(fCntB));
  pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(2)) dutC (
    .clk(clk), .arst_n(arst_n), .bus(ifs[2]), .stall_cnt_o(sCntC), .flush_cnt_o(fCntC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t sIdle();
    stim_t s;
    s = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  // lw x5 in EX, add x6,x5,x1 in ID
  function automatic stim_t sHaz();
    stim_t s;
    s = sIdle();
    s.load = 1'b1; s.wena = 1'b1; s.rd = 5'd5;
    s.rs1 = 5'd5; s.use1 = 1'b1; s.rs2 = 5'd1; s.use2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t sJmp(input logic [31:0] a);
    stim_t s;
    s = sIdle();
    s.jmp = 1'b1; s.jaddr = a;
    return s;
  endfunction

  function automatic stim_t withHold(input stim_t s);
    stim_t r;
    r = s;
    r.hold = 1'b1;
    return r;
  endfunction

  function automatic stim_t withReset(input stim_t s);
    stim_t r;
    r = s;
    r.rstn = 1'b0;
    return r;
  endfunction

  function automatic exp_t ex(input int d, input string n, input logic [5:0] c,
                              input logic [31:0] a, input logic [31:0] s, input logic [31:0] f);
    exp_t e;
    e.dut = d; e.name = n; e.ctl = c; e.addr = a; e.sCnt = s; e.fCnt = f;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    st = s;
    expQ.push_back(e);
  endtask

  task automatic cmp(input string n, input string field, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", n, field, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [5:0]  ctl;
    logic [31:0] addr, sc, fc;
    case (e.dut)
      0: begin
        ctl  = {ifs[0].jump_ena_o, ifs[0].pc_stall_o, ifs[0].if_id_stall_o,
                ifs[0].if_id_flush_o, ifs[0].id_ex_stall_o, ifs[0].id_ex_flush_o};
        addr = ifs[0].jump_addr_o; sc = sCntA; fc = fCntA;
      end
      1: begin
        ctl  = {ifs[1].jump_ena_o, ifs[1].pc_stall_o, ifs[1].if_id_stall_o,
                ifs[1].if_id_flush_o, ifs[1].id_ex_stall_o, ifs[1].id_ex_flush_o};
        addr = ifs[1].jump_addr_o; sc = sCntB; fc = fCntB;
      end
      default: begin
        ctl  = {ifs[2].jump_ena_o, ifs[2].pc_stall_o, ifs[2].if_id_stall_o,
                ifs[2].if_id_flush_o, ifs[2].id_ex_stall_o, ifs[2].id_ex_flush_o};
        addr = ifs[2].jump_addr_o; sc = 32'(sCntC); fc = 32'(fCntC);
      end
    endcase
    cmp(e.name, "ctl", 32'(ctl), 32'(e.ctl));
    cmp(e.name, "addr", addr, e.addr);
    cmp(e.name, "stallCnt", sc, e.sCnt);
    cmp(e.name, "flushCnt", fc, e.fCnt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin : stimulus
    testsRun    = 0;
    testsFailed = 0;
    st = withReset(sIdle());

    // LOAD_LAT=1 instance
    applyStimulus(withReset(sHaz()), ex(0, "A.rstHaz", C_NONE, 0, 0, 0));
    applyStimulus(sHaz(), ex(0, "A.haz", C_HAZ, 0, 0, 0));
    applyStimulus(sIdle(), ex(0, "A.afterHaz", C_NONE, 0, 1, 0));
    begin
      stim_t s;
      s = sHaz(); s.rd = 5'd0; s.rs1 = 5'd0;
      applyStimulus(s, ex(0, "A.rdX0", C_NONE, 0, 1, 0));
      s = sHaz(); s.use1 = 1'b0;
      applyStimulus(s, ex(0, "A.noUse", C_NONE, 0, 1, 0));
      s = sHaz(); s.rs1 = 5'd1; s.rs2 = 5'd5;
      applyStimulus(s, ex(0, "A.rs2Haz", C_HAZ, 0, 1, 0));
      s = sHaz(); s.load = 1'b0;
      applyStimulus(s, ex(0, "A.noLoad", C_NONE, 0, 2, 0));
    end
    applyStimulus(sJmp(32'h100), ex(0, "A.jmp", C_JMP, 32'h100, 2, 0));
    applyStimulus(sIdle(), ex(0, "A.afterJmp", C_NONE, 0, 2, 1));
    begin
      stim_t s;
      s = sHaz(); s.jmp = 1'b1; s.jaddr = 32'h200;
      applyStimulus(s, ex(0, "A.jmpOverHaz", C_JMP, 32'h200, 2, 1));
    end
    applyStimulus(withHold(sJmp(32'h300)), ex(0, "A.holdJmp1", C_HOLD, 0, 2, 2));
    applyStimulus(withHold(sJmp(32'h300)), ex(0, "A.holdJmp2", C_HOLD, 0, 3, 2));
    applyStimulus(sJmp(32'h300), ex(0, "A.releaseJmp", C_JMP, 32'h300, 4, 2));
    applyStimulus(sIdle(), ex(0, "A.end", C_NONE, 0, 4, 3));

    // LOAD_LAT=3 instance: plain three-bubble sequence
    applyStimulus(withReset(sIdle()), ex(1, "B.rst", C_NONE, 0, 0, 0));
    applyStimulus(sHaz(), ex(1, "B.bub1", C_HAZ, 0, 0, 0));
    applyStimulus(sIdle(), ex(1, "B.bub2", C_HAZ, 0, 1, 0));
    applyStimulus(sIdle(), ex(1, "B.bub3", C_HAZ, 0, 2, 0));
    applyStimulus(sIdle(), ex(1, "B.run4", C_NONE, 0, 3, 0));

    // hold for 4 cycles during the 2nd bubble
    applyStimulus(withReset(sIdle()), ex(1, "B.rst2", C_NONE, 0, 0, 0));
    applyStimulus(sHaz(), ex(1, "B.hBub1", C_HAZ, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      applyStimulus(withHold(sIdle()), ex(1, $sformatf("B.hold%0d", i), C_HOLD, 0, 1 + i, 0));
    applyStimulus(sIdle(), ex(1, "B.hBub2", C_HAZ, 0, 5, 0));
    applyStimulus(sIdle(), ex(1, "B.hBub3", C_HAZ, 0, 6, 0));
    applyStimulus(sIdle(), ex(1, "B.hRun", C_NONE, 0, 7, 0));

    // reset in the middle of LSTALL, hazard inputs still live
    applyStimulus(sHaz(), ex(1, "B.preRst", C_HAZ, 0, 7, 0));
    applyStimulus(withReset(sHaz()), ex(1, "B.midRst", C_NONE, 0, 0, 0));
    applyStimulus(sIdle(), ex(1, "B.postRst1", C_NONE, 0, 0, 0));
    applyStimulus(sIdle(), ex(1, "B.postRst2", C_NONE, 0, 0, 0));

    // jump arriving while bubbles are pending
    applyStimulus(sHaz(), ex(1, "B.jBub1", C_HAZ, 0, 0, 0));
    applyStimulus(sJmp(32'h400), ex(1, "B.lstallJmp", C_JMP, 32'h400, 1, 0));
    applyStimulus(sIdle(), ex(1, "B.afterLJmp", C_NONE, 0, 1, 1));

    // CNT_W=2 instance: saturation at 3
    applyStimulus(withReset(sIdle()), ex(2, "C.rst", C_NONE, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      applyStimulus(sHaz(), ex(2, $sformatf("C.haz%0d", i), C_HAZ, 0, (i < 3) ? i : 3, 0));
    for (int i = 0; i < 5; i++)
      applyStimulus(sJmp(32'h40 + 32'(i)), ex(2, $sformatf("C.jmp%0d", i), C_JMP,
                                              32'h40 + 32'(i), 3, (i < 3) ? i : 3));
    applyStimulus(sIdle(), ex(2, "C.sat", C_NONE, 0, 3, 3));

    @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
